dt_core: RTL and testbench

- Distance-transform engine; the initiator side of the stimulus-ROM / result-RAM interface.
- Reads a 128×128 binary image packed 16 pixels per ROM word.
- Computes the chessboard distance of every object pixel to the nearest background pixel using a forward raster pass, then a backward raster pass, working in place in the result RAM.
- Asserts `done` when the RAM holds the final map.

---
 rtl/dt_pkg.sv | 43 ++++
 rtl/dt_min_acc.sv | 31 +++
 rtl/dt_core.sv | 176 +++++++++++++++++
 tb/tb_dt_core.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dt_pkg.sv
// rtl/dt_pkg.sv - shared constants, FSM states and address helpers for the distance-transform engine
package dt_pkg;

    localparam int IMG_W  = 128;
    localparam int DIST_W = 8;
    localparam int ROW_W  = 7;
    localparam int PIX_W  = 14;
    localparam int STI_AW = 10;
    localparam int STI_DW = 16;

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(IMG_W * IMG_W - 1);

    localparam int OFF_W  = -1;
    localparam int OFF_E  = 1;
    localparam int OFF_NE = -127;
    localparam int OFF_SW = 127;
    localparam int OFF_N  = -128;
    localparam int OFF_S  = 128;
    localparam int OFF_NW = -129;
    localparam int OFF_SE = 129;

    typedef enum logic [3:0] {
        IDLE,
        FW_FETCH,
        FW_RD,
        FW_WR,
        FW_DONE,
        BW_SELF,
        BW_RD,
        BW_WR,
        DONE
    } dt_state_t;

    function automatic logic is_border(input logic [PIX_W-1:0] p);
        return (p[PIX_W-1:ROW_W] == '0) || (p[PIX_W-1:ROW_W] == '1) ||
               (p[ROW_W-1:0] == '0) || (p[ROW_W-1:0] == '1);
    endfunction

    function automatic logic [PIX_W-1:0] nbr_addr(input logic [PIX_W-1:0] p, input int off);
        return PIX_W'(int'({18'd0, p}) + off);
    endfunction

endpackage

// File: rtl/dt_min_acc.sv
// rtl/dt_min_acc.sv - running minimum of (neighbour+1, saturating) with clear-to-max and raw load
module dt_min_acc
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clr,
    input  logic              load,
    input  logic [DIST_W-1:0] load_val,
    input  logic              en,
    input  logic [DIST_W-1:0] din,
    output logic [DIST_W-1:0] q
);

    logic [DIST_W-1:0] inc;

    assign inc = (din == '1) ? din : din + DIST_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (clr) begin
            q <= '1;
        end else if (load) begin
            q <= load_val;
        end else if (en && (inc < q)) begin
            q <= inc;
        end
    end

endmodule

// File: rtl/dt_core.sv
// rtl/dt_core.sv - two-pass chessboard distance transform, ROM in / RAM in-place; DT_FWPASS_FLAG_EN adds fwpass_finish
module dt_core
    import dt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
`ifdef DT_FWPASS_FLAG_EN
    output logic              fwpass_finish,
`endif
    output logic              done,
    output logic              sti_rd,
    output logic [STI_AW-1:0] sti_addr,
    input  logic [STI_DW-1:0] sti_di,
    output logic              res_wr,
    output logic              res_rd,
    output logic [PIX_W-1:0]  res_addr,
    output logic [DIST_W-1:0] res_do,
    input  logic [DIST_W-1:0] res_di
);

    dt_state_t         state, state_n;
    logic [PIX_W-1:0]  pix, pix_n, nxt_pix;
    logic [1:0]        idx, idx_n;
    logic [STI_DW-1:0] word, word_n;
    logic              nxt_obj;
    logic              acc_clr, acc_load, acc_en;
    logic [DIST_W-1:0] acc_load_val, acc_q;

    dt_min_acc u_acc (
        .clk      (clk),
        .reset    (reset),
        .clr      (acc_clr),
        .load     (acc_load),
        .load_val (acc_load_val),
        .en       (acc_en),
        .din      (res_di),
        .q        (acc_q)
    );

    // The accumulator register doubles as the write-data register.
    assign res_do = acc_q;
    assign done   = (state == DONE);
`ifdef DT_FWPASS_FLAG_EN
    assign fwpass_finish = (state == FW_DONE);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pix   <= '0;
            idx   <= '0;
            word  <= '0;
        end else begin
            state <= state_n;
            pix   <= pix_n;
            idx   <= idx_n;
            word  <= word_n;
        end
    end

    always_comb begin
        state_n      = state;
        pix_n        = pix;
        idx_n        = idx;
        word_n       = word;
        sti_rd       = 1'b0;
        sti_addr     = '0;
        res_rd       = 1'b0;
        res_wr       = 1'b0;
        res_addr     = '0;
        acc_clr      = 1'b0;
        acc_load     = 1'b0;
        acc_en       = 1'b0;
        acc_load_val = (state == BW_SELF) ? res_di : '0;
        nxt_pix      = pix + PIX_W'(1);
        nxt_obj      = word[4'd15 - nxt_pix[3:0]] && !is_border(nxt_pix);

        case (state)
            IDLE: begin
                pix_n   = '0;
                state_n = FW_FETCH;
            end
            FW_FETCH: begin
                sti_rd   = 1'b1;
                sti_addr = pix[PIX_W-1:4];
                word_n   = sti_di;
                if (sti_di[15] && !is_border(pix)) begin
                    acc_clr = 1'b1;
                    idx_n   = '0;
                    state_n = FW_RD;
                end else begin
                    acc_load = 1'b1;
                    state_n  = FW_WR;
                end
            end
            FW_RD: begin
                res_rd = 1'b1;
                acc_en = 1'b1;
                case (idx)
                    2'd0:    res_addr = nbr_addr(pix, OFF_NW);
                    2'd1:    res_addr = nbr_addr(pix, OFF_N);
                    2'd2:    res_addr = nbr_addr(pix, OFF_NE);
                    default: res_addr = nbr_addr(pix, OFF_W);
                endcase
                idx_n = idx + 2'd1;
                if (idx == 2'd3) state_n = FW_WR;
            end
            FW_WR: begin
                res_wr   = 1'b1;
                res_addr = pix;
                if (pix == LAST_PIX) begin
                    state_n = FW_DONE;
                end else begin
                    pix_n = nxt_pix;
                    if (nxt_pix[3:0] == 4'd0) begin
                        state_n = FW_FETCH;
                    end else if (nxt_obj) begin
                        acc_clr = 1'b1;
                        idx_n   = '0;
                        state_n = FW_RD;
                    end else begin
                        acc_load = 1'b1;
                        state_n  = FW_WR;
                    end
                end
            end
            FW_DONE: begin
                pix_n   = LAST_PIX;
                state_n = BW_SELF;
            end
            BW_SELF: begin
                if (is_border(pix)) begin
                    if (pix == '0) state_n = DONE;
                    else           pix_n   = pix - PIX_W'(1);
                end else begin
                    res_rd   = 1'b1;
                    res_addr = pix;
                    acc_load = 1'b1;
                    idx_n    = '0;
                    state_n  = BW_RD;
                end
            end
            BW_RD: begin
                // A zero self value is already final; the first BW_RD cycle drops it.
                if (idx == 2'd0 && acc_q == '0) begin
                    pix_n   = pix - PIX_W'(1);
                    state_n = BW_SELF;
                end else begin
                    res_rd = 1'b1;
                    acc_en = 1'b1;
                    case (idx)
                        2'd0:    res_addr = nbr_addr(pix, OFF_E);
                        2'd1:    res_addr = nbr_addr(pix, OFF_SW);
                        2'd2:    res_addr = nbr_addr(pix, OFF_S);
                        default: res_addr = nbr_addr(pix, OFF_SE);
                    endcase
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = BW_WR;
                end
            end
            BW_WR: begin
                res_wr   = 1'b1;
                res_addr = pix;
                pix_n    = pix - PIX_W'(1);
                state_n  = BW_SELF;
            end
            DONE: begin
                state_n = DONE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dt_core.sv
// tb/tb_dt_core.sv - directed bench: combined object image, mid-backward reset, chessboard-distance model
module tb_dt_core;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        done, sti_rd, res_wr, res_rd;
    logic [9:0]  sti_addr;
    logic [15:0] sti_di;
    logic [13:0] res_addr;
    logic [7:0]  res_do, res_di;
`ifdef DT_FWPASS_FLAG_EN
    logic        fwpass_finish;
    int          pulses;
`endif

    logic [15:0] rom [0:1023];
    logic [7:0]  ram [0:16383];
    int          exp_map [0:16383];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          fw_next, t0, t1;
    bit          fw_done, bw_seen, first_rd;

    dt_core dut (
        .clk      (clk),
        .reset    (reset),
`ifdef DT_FWPASS_FLAG_EN
        .fwpass_finish (fwpass_finish),
`endif
        .done     (done),
        .sti_rd   (sti_rd),
        .sti_addr (sti_addr),
        .sti_di   (sti_di),
        .res_wr   (res_wr),
        .res_rd   (res_rd),
        .res_addr (res_addr),
        .res_do   (res_do),
        .res_di   (res_di)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (sti_rd) sti_di <= rom[sti_addr];
        if (res_rd) res_di <= ram[res_addr];
    end
    always @(posedge clk) if (res_wr) ram[res_addr] <= res_do;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_pix(input int r, input int c);
        int p;
        p = r * 128 + c;
        rom[p >> 4][15 - (p & 15)] = 1'b1;
    endtask

    function automatic bit is_bg(input int r, input int c);
        int p;
        logic [15:0] w;
        if (r <= 0 || r >= 127 || c <= 0 || c >= 127) return 1'b1;
        p = r * 128 + c;
        w = rom[p >> 4];
        return w[15 - (p & 15)] == 1'b0;
    endfunction

    // Chessboard distance from each object pixel to the nearest background or border pixel.
    task automatic build_model();
        for (int p = 0; p < 16384; p++) begin
            int r, c, d;
            r = p / 128;
            c = p % 128;
            d = 0;
            if (!is_bg(r, c)) begin
                for (int rad = 1; rad < 128 && d == 0; rad++)
                    for (int dr = -rad; dr <= rad; dr++)
                        for (int dc = -rad; dc <= rad; dc++)
                            if ((dr == rad || dr == -rad || dc == rad || dc == -rad) &&
                                r + dr >= 0 && r + dr < 128 && c + dc >= 0 && c + dc < 128 &&
                                d == 0 && is_bg(r + dr, c + dc))
                                d = rad;
                if (d > 255) d = 255;
            end
            exp_map[p] = d;
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (reset) begin
            fw_next  = 0;
            fw_done  = 1'b0;
            bw_seen  = 1'b0;
            first_rd = 1'b1;
`ifdef DT_FWPASS_FLAG_EN
            pulses   = 0;
`endif
        end else begin
            if (sti_rd || res_rd || res_wr)
                check("enable_exclusive", int'((res_rd && res_wr) || (sti_rd && (res_rd || res_wr))), 0);
            if (done)
                check("done_enables_low", int'(sti_rd || res_rd || res_wr), 0);
            if (sti_rd && first_rd) begin
                check("first_sti_addr", int'(sti_addr), 0);
                first_rd = 1'b0;
                t0 = cyc;
            end
            if (res_wr && !fw_done) begin
                check("fw_wr_addr", int'(res_addr), fw_next);
                if (exp_map[res_addr] == 0) check("fw_wr_zero", int'(res_do), 0);
                else check("fw_wr_upper_bound", int'(int'(res_do) >= exp_map[res_addr]), 1);
                fw_next++;
                if (res_addr == 14'd16383) begin
                    fw_done = 1'b1;
                    t1 = cyc;
                end
            end else if (res_wr) begin
                check("bw_wr_value", int'(res_do), exp_map[res_addr]);
            end
            if (res_rd && fw_done) bw_seen = 1'b1;
`ifdef DT_FWPASS_FLAG_EN
            if (fwpass_finish) begin
                pulses++;
                check("fwflag_before_bw", int'(bw_seen), 0);
                check("fwflag_res1290", int'(ram[1290]), 2);
                check("fwflag_res1418", int'(ram[1418]), 2);
            end
`endif
        end
    end

    initial begin
        int bad, first_bad;
        for (int i = 0; i < 1024; i++) rom[i] = '0;
        set_pix(64, 64);
        for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++) set_pix(10 + dr, 10 + dc);
        for (int dr = -2; dr <= 2; dr++)
            for (int dc = -2; dc <= 2; dc++) set_pix(40 + dr, 40 + dc);
        build_model();

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", int'(|{done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}), 0);
        reset = 1'b0;

        for (int i = 0; i < 40000 && !bw_seen; i++) @(negedge clk);
        check("reach_backward", int'(bw_seen), 1);
        // 1024 fetches + 16384 pixel cycles + 4 read cycles per each of 35 object pixels
        check("fw_cycles", t1 - t0 + 1, 17548);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrun_reset_outputs", int'(|{done, sti_rd, res_rd, res_wr, sti_addr, res_addr, res_do}), 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 60000 && !done; i++) @(negedge clk);
        check("done_rise", int'(done), 1);

        bad = 0;
        first_bad = -1;
        for (int p = 0; p < 16384; p++)
            if (int'(ram[p]) != exp_map[p]) begin
                bad++;
                if (first_bad < 0) first_bad = p;
            end
        check("ram_vs_model_mismatches", bad, 0);
        if (bad != 0) check("ram_first_bad_addr", first_bad, -1);

        check("res8256_single", int'(ram[8256]), 1);
        check("res8257_bg", int'(ram[8257]), 0);
        check("res1290_centre3x3", int'(ram[1290]), 2);
        check("res1289_ring", int'(ram[1289]), 1);
        check("res1162_ring", int'(ram[1162]), 1);
        check("res1418_ring", int'(ram[1418]), 1);
        check("res1419_ring", int'(ram[1419]), 1);
        check("res5160_centre5x5", int'(ram[5160]), 3);
        check("res5161_ring1", int'(ram[5161]), 2);
        check("res5289_ring1", int'(ram[5289]), 2);
        check("res5416_outer_bottom", int'(ram[5416]), 1);
        check("res5418_outer_corner", int'(ram[5418]), 1);
        check("res0_border", int'(ram[0]), 0);

        repeat (5) @(negedge clk);
        check("done_held", int'(done), 1);
`ifdef DT_FWPASS_FLAG_EN
        check("fwflag_pulse_cycles", pulses, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
